// File: rtl/ext_pipe.sv
// Pipelined immediate extender with a 2-entry (main + skid) valid/ready buffer.
// Outputs come straight from the main register; in_ready depends only on occupancy.
module ext_pipe #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SHAMT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext,
    output logic              bad_op
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] m_ext, k_ext;
    logic              m_bad, k_bad;
    logic [DATA_W-1:0] new_ext;
    logic              new_bad;
    logic [DATA_W-1:0] sx, zx;
    logic              in_xfer, out_xfer;

    always_comb begin
        sx      = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        zx      = {{(DATA_W-IMM_W){1'b0}}, imm};
        new_ext = '0;
        new_bad = 1'b0;
        case (eop)
            3'b000:  new_ext = sx;
            3'b001:  new_ext = zx;
            3'b010:  new_ext = {imm, {(DATA_W-IMM_W){1'b0}}};
            3'b011:  new_ext = sx << SHAMT;
            3'b100:  new_ext = zx << SHAMT;
            default: new_bad = 1'b1;
        endcase
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign ext       = m_ext;
    assign bad_op    = m_bad;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            m_ext <= '0;
            m_bad <= 1'b0;
            k_ext <= '0;
            k_bad <= 1'b0;
        end else if (flush) begin
            // Entry contents are left stale; out_valid gates them.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        m_ext <= new_ext;
                        m_bad <= new_bad;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_ext <= new_ext;
                        m_bad <= new_bad;
                    end else if (out_xfer) begin
                        state <= EMPTY;
                    end else if (in_xfer) begin
                        k_ext <= new_ext;
                        k_bad <= new_bad;
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        m_ext <= k_ext;
                        m_bad <= k_bad;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: driver pushes hand-computed results, monitor pops on output transfers.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] imm = '0;
    logic [2:0]  eop = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ext;
    logic        bad_op;

    logic        v_in_valid = 1'b0;
    logic        v_in_ready;
    logic [7:0]  v_imm = '0;
    logic [2:0]  v_eop = '0;
    logic        v_out_valid;
    logic [15:0] v_ext;
    logic        v_bad_op;

    int unsigned applied = 0;
    int unsigned miscompares = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    ext_pipe #(.IMM_W(16), .DATA_W(32), .SHAMT(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .imm(imm), .eop(eop),
        .out_valid(out_valid), .out_ready(out_ready), .ext(ext), .bad_op(bad_op)
    );

    ext_pipe #(.IMM_W(8), .DATA_W(16), .SHAMT(1)) dut_v (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(v_in_valid), .in_ready(v_in_ready), .imm(v_imm), .eop(v_eop),
        .out_valid(v_out_valid), .out_ready(1'b1), .ext(v_ext), .bad_op(v_bad_op)
    );

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Output monitor: every transfer must match the oldest pending expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {bad_op, ext}, 33'h1_DEAD_BEEF);
                end else begin
                    check("sb_output", {bad_op, ext}, sb.pop_front());
                end
            end
        end
    end

    // Presents one entry from posedge+1, waits (bounded) for acceptance, returns at posedge+1.
    task automatic send(input logic [15:0] i, input logic [2:0] e, input logic [32:0] exp, input bit push);
        bit ok;
        ok = 1'b0;
        imm = i; eop = e; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 33'd0, 33'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", 33'(sb.size()), 33'd0);
    endtask

    task automatic vsend(input logic [7:0] i, input logic [2:0] e, input logic [16:0] exp, input string name);
        v_imm = i; v_eop = e; v_in_valid = 1'b1;
        @(posedge clk); #1;
        v_in_valid = 1'b0;
        check(name, {16'd0, v_out_valid, v_bad_op, v_ext[14:0]} | 33'(v_ext[15]) << 15,
              {16'd0, 1'b1, exp[16], exp[14:0]} | 33'(exp[15]) << 15);
    endtask

    initial begin
        #12;
        check("reset_state", {in_ready, out_valid, bad_op, ext}, {1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Modes, full throughput.
        out_ready = 1'b1;
        send(16'h8004, 3'b000, {1'b0, 32'hFFFF8004}, 1'b1);
        check("latency_one", {out_valid, bad_op, ext}, {1'b1, 1'b0, 32'hFFFF8004});
        send(16'h8004, 3'b001, {1'b0, 32'h00008004}, 1'b1);
        send(16'h8004, 3'b010, {1'b0, 32'h80040000}, 1'b1);
        send(16'h8004, 3'b011, {1'b0, 32'hFFFE0010}, 1'b1);
        check("simul_in_ready", {32'd0, in_ready}, 33'd1);
        send(16'h8004, 3'b100, {1'b0, 32'h00020010}, 1'b1);
        send(16'h8004, 3'b110, {1'b1, 32'h00000000}, 1'b1);
        send(16'h1234, 3'b111, {1'b1, 32'h00000000}, 1'b1);
        send(16'h7FFF, 3'b000, {1'b0, 32'h00007FFF}, 1'b1);
        drain();

        // Backpressure: A held in M, B in skid, C waits.
        out_ready = 1'b0;
        send(16'h00A1, 3'b001, {1'b0, 32'h000000A1}, 1'b1);
        send(16'h00B2, 3'b011, {1'b0, 32'h000002C8}, 1'b1);
        check("bp_in_ready_low", {31'd0, in_ready, out_valid}, 33'b01);
        repeat (2) @(posedge clk);
        #1;
        check("bp_hold_a", {bad_op, ext}, {1'b0, 32'h000000A1});
        fork
            send(16'hFFC3, 3'b010, {1'b0, 32'hFFC30000}, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Flush while FULL with an input presented.
        out_ready = 1'b0;
        send(16'h0011, 3'b000, 33'd0, 1'b0);
        send(16'h0022, 3'b000, 33'd0, 1'b0);
        imm = 16'h0033; eop = 3'b000; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_state", {31'd0, out_valid, in_ready}, 33'b01);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_no_out", {32'd0, out_valid}, 33'd0);

        // Asynchronous reset between edges while FULL.
        out_ready = 1'b0;
        send(16'h0044, 3'b001, 33'd0, 1'b0);
        send(16'h0055, 3'b001, 33'd0, 1'b0);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_reset", {in_ready, out_valid, bad_op, ext}, {1'b1, 1'b0, 1'b0, 32'd0});
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'hF00D, 3'b001, {1'b0, 32'h0000F00D}, 1'b1);
        check("post_reset_latency", {out_valid, bad_op, ext}, {1'b1, 1'b0, 32'h0000F00D});
        drain();

        // Narrow parameter variant.
        vsend(8'hC1, 3'b000, {1'b0, 16'hFFC1}, "var_sext");
        vsend(8'hC1, 3'b010, {1'b0, 16'hC100}, "var_lui");
        vsend(8'hC1, 3'b011, {1'b0, 16'hFF82}, "var_branch");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined immediate-extension stage for the MIPS datapath. It takes an IMM_W-bit immediate and a 3-bit extension opcode and produces a registered DATA_W-bit extended operand. Input and output use valid/ready handshakes, with a 2-entry skid buffer, so the ID/EX boundary can stall and flush without losing or duplicating operands. It replaces the purely combinational extender between instruction decode and the ALU/branch-target path.

## Interface
- IMM_W, 16, immediate width; must satisfy 2 ≤ IMM_W < DATA_W
- DATA_W, 32, output operand width
- SHAMT, 2, left-shift amount for the branch-offset modes; must satisfy 0 ≤ SHAMT < DATA_W

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush; discards all held entries
- in_valid  in  1  imm/eop are valid this cycle
- in_ready  out  1  stage can accept an entry this cycle
- imm  in  IMM_W  raw immediate field
- eop  in  3  extension opcode
- out_valid  out  1  ext/bad_op are valid
- out_ready  in  1  consumer accepts the entry this cycle
- ext  out  DATA_W  extended operand
- bad_op  out  1  the entry carried a reserved eop

## Operation
- Let S = sign-extension of imm to DATA_W, and Z = zero-extension of imm to DATA_W. All results are truncated to DATA_W.
- The eop encodings are:
  - 000: S
  - 001: Z
  - 010: imm placed in the top IMM_W bits, low DATA_W-IMM_W bits zero (lui)
  - 011: S << SHAMT (branch offset)
  - 100: Z << SHAMT
  - 101/110/111: reserved; ext = 0 and bad_op = 1
- The result is computed combinationally from the input and stored with bad_op as a single entry.
- Storage is a main register M, which drives the outputs, plus a skid register K. The occupancy states are:
  - EMPTY: M invalid, K invalid
  - ONE: M valid, K invalid
  - FULL: M valid, K valid
- The input transfers when in_valid && in_ready. The output transfers when out_valid && out_ready.
- State transitions:
  - EMPTY + input transfer → ONE; the entry goes to M.
  - ONE + input transfer + output transfer → ONE; M is replaced by the new entry.
  - ONE + output transfer only → EMPTY.
  - ONE + input transfer only → FULL; the new entry goes to K.
  - FULL + output transfer → ONE; K moves to M. No input can transfer in FULL.
  - No transfer → hold all contents.
- in_ready = (state != FULL). It is a registered-state function only and has no combinational path from out_ready.
- out_valid = (state != EMPTY). ext and bad_op come directly from M and are stable while out_valid && !out_ready.
- Entries leave in strict FIFO order; none is dropped or duplicated.
- flush has priority over every transfer:
  - The next state is EMPTY.
  - Any input presented in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts as consumed.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) sets: state EMPTY, out_valid 0, in_ready 1, ext 0, bad_op 0, K contents 0.
- Latency: an input accepted at edge N is visible on the outputs after edge N when the stage was EMPTY, or was ONE with an output transfer in that cycle. Otherwise it follows the older entry.
- Throughput is one entry per cycle while out_ready stays high.
- After out_ready drops, the stage accepts exactly one more entry (into K), then deasserts in_ready.
- Recovery: in_ready returns high the cycle after the first output transfer out of FULL.
- Flush: outputs are invalid and in_ready is high in the cycle after the flush edge.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge. All held entries are lost.
- Reserved eop values never produce X on the outputs.

## Test plan
- Modes at default parameters, out_ready = 1:
  - imm = 16'h8004 with eop 000/001/010/011/100 → ext = FFFF8004 / 00008004 / 80040000 / FFFE0010 / 00020010, in order, at 1 entry per cycle, bad_op = 0.
  - eop = 110 → ext = 0, bad_op = 1.
- Backpressure:
  - Send A, B, C back-to-back while out_ready = 0 → A is held, B goes to K, in_ready falls after B, C waits.
  - Raise out_ready → A, B, C appear in order with no loss or duplicate.
- Simultaneous transfer in ONE: in-transfer and out-transfer in the same cycle → state remains ONE, M holds the new value, in_ready stays 1.
- Flush in FULL with in_valid = 1 → the next cycle has out_valid = 0, in_ready = 1, and the presented entry never appears.
- Asynchronous reset pulse between clock edges while FULL → out_valid and ext clear immediately; after release, the first new input appears with 1-cycle latency.
- Parameter variant IMM_W = 8, DATA_W = 16, SHAMT = 1:
  - imm = 8'hC1: eop 000 → FFC1; eop 010 → C100; eop 011 → FF82.
